// File: rtl/ahb_rambus_bridge.sv
// AHB-Lite to 16-bit RamBus bridge; each half costs SETUP + STROBE_CYCLES + HOLD (4/8 cycles halfword/word), HREADYOUT low until the final HOLD.
// Optional RAMBUS_WAIT_EN: RamBusWait stretches the last STROBE cycle; a 16-cycle watchdog ends a stuck access with ERROR.
module ahb_rambus_bridge #(
    parameter int ADDR_WIDTH    = 10,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] RamBusAddress,
    output logic                  RamBusnCs,
    output logic                  RamBusWE,
    output logic                  RamBusOE,
    output logic [15:0]           RamBusDataOut,
    input  logic [15:0]           RamBusDataIn,
`ifdef RAMBUS_WAIT_EN
    input  logic                  RamBusWait,
`endif
    output logic                  RamBusDataOe
);
    localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ERR1, ERR2} state_t;

    state_t              state, nextState;
    logic [CW-1:0]       strbCnt;
    logic [ADDR_WIDTH:0] addrReg;
    logic                isWrite, isWord, secondHalf;
    logic [31:0]         wdataReg, wsrc;
    logic [15:0]         rdLow;
    logic                accept, legal, lastStrobe, stretch, timeout, sampleNow, finalHold;
    logic                unusedBits;

    assign unusedBits = &{1'b0, HADDR[31:ADDR_WIDTH+1], HTRANS[0]};

    assign legal      = (HSIZE == 3'd2 && HADDR[1:0] == 2'b00) || (HSIZE == 3'd1 && !HADDR[0]);
    assign accept     = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign lastStrobe = (state == STROBE) && (strbCnt == CW'(STROBE_CYCLES - 1));
    assign finalHold  = (state == HOLD) && !(isWord && !secondHalf);
    assign sampleNow  = lastStrobe && !stretch;

`ifdef RAMBUS_WAIT_EN
    logic [3:0] waitCnt;
    assign stretch = lastStrobe && RamBusWait;
    assign timeout = stretch && (waitCnt == 4'd15);

    always_ff @(posedge clk) begin
        if (rst || state != STROBE) waitCnt <= '0;
        else if (stretch)           waitCnt <= waitCnt + 1'b1;
    end
`else
    assign stretch = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        nextState = state;
        case (state)
            IDLE, ERR2: nextState = accept ? (legal ? SETUP : ERR1) : IDLE;
            ERR1:       nextState = ERR2;
            SETUP:      nextState = STROBE;
            STROBE: begin
                if (timeout)        nextState = ERR1;
                else if (sampleNow) nextState = HOLD;
            end
            // Final HOLD doubles as the next address phase, so pipelined accesses keep nCs low.
            HOLD: begin
                if (!finalHold)  nextState = SETUP;
                else if (accept) nextState = legal ? SETUP : ERR1;
                else             nextState = IDLE;
            end
            default:    nextState = IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT    = 1'b0;
        HRESP        = 1'b0;
        RamBusnCs    = 1'b1;
        RamBusWE     = 1'b0;
        RamBusOE     = 1'b0;
        RamBusDataOe = 1'b0;
        case (state)
            IDLE:  HREADYOUT = 1'b1;
            ERR1:  HRESP = 1'b1;
            ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
            SETUP: begin
                RamBusnCs    = 1'b0;
                RamBusDataOe = isWrite;
            end
            STROBE: begin
                RamBusnCs    = 1'b0;
                RamBusDataOe = isWrite;
                RamBusWE     = isWrite;
                RamBusOE     = !isWrite;
            end
            HOLD: begin
                RamBusnCs    = 1'b0;
                RamBusDataOe = isWrite;
                HREADYOUT    = finalHold;
            end
            default: ;
        endcase
    end

    // HWDATA only becomes valid in the first data-phase cycle, so SETUP of the first half drives it straight through.
    assign wsrc          = (state == SETUP && !secondHalf && isWrite) ? HWDATA : wdataReg;
    assign RamBusDataOut = (isWord ? secondHalf : addrReg[1]) ? wsrc[31:16] : wsrc[15:0];
    assign RamBusAddress = isWord ? {addrReg[ADDR_WIDTH:2], secondHalf} : addrReg[ADDR_WIDTH:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            strbCnt    <= '0;
            addrReg    <= '0;
            isWrite    <= 1'b0;
            isWord     <= 1'b0;
            secondHalf <= 1'b0;
            wdataReg   <= '0;
            rdLow      <= '0;
            HRDATA     <= '0;
        end else begin
            state <= nextState;
            if (state == STROBE && !lastStrobe) strbCnt <= strbCnt + 1'b1;
            else if (state != STROBE)           strbCnt <= '0;
            if (accept && legal) begin
                addrReg    <= HADDR[ADDR_WIDTH:0];
                isWrite    <= HWRITE;
                isWord     <= (HSIZE == 3'd2);
                secondHalf <= 1'b0;
            end else if (state == HOLD && !finalHold) begin
                secondHalf <= 1'b1;
            end
            if (state == SETUP && !secondHalf && isWrite) wdataReg <= HWDATA;
            // Low half is parked so HRDATA changes only when the whole read completes.
            if (sampleNow && !isWrite) begin
                if (!isWord)         HRDATA <= {RamBusDataIn, RamBusDataIn};
                else if (!secondHalf) rdLow <= RamBusDataIn;
                else                 HRDATA <= {RamBusDataIn, rdLow};
            end
        end
    end
endmodule

// File: tb/tb_ahb_rambus_bridge.sv
// Bench for ahb_rambus_bridge: vector table, pipelined and reset sequences, then random traffic
// against a halfword memory model; the bench also plays the RamBus device.
module tb_ahb_rambus_bridge;
    localparam int AW = 10;
    localparam int S  = 2;
    localparam int P  = S + 2;
    localparam int NR = 30;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        xfer_t       x;
        int          expLow;
        logic        expResp;
        logic [31:0] expRd;
    } vec_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic          HSEL = 1'b0, HWRITE = 1'b0, HREADY;
    logic [31:0]   HADDR = '0, HWDATA = '0, HRDATA;
    logic [1:0]    HTRANS = '0;
    logic [2:0]    HSIZE = '0;
    logic          HREADYOUT, HRESP;
    logic [AW-1:0] RamBusAddress;
    logic          RamBusnCs, RamBusWE, RamBusOE, RamBusDataOe;
    logic [15:0]   RamBusDataOut, RamBusDataIn;
`ifdef RAMBUS_WAIT_EN
    logic          RamBusWait = 1'b0;
`endif

    logic [15:0] ramMem [0:(1<<AW)-1];
    logic [15:0] refMem [0:(1<<AW)-1];
    logic [31:0] lastRd = '0;
    int nChk = 0;
    int nPass = 0;

    always #5 clk = ~clk;
    assign HREADY       = HREADYOUT;
    assign RamBusDataIn = ramMem[RamBusAddress];
    always @(posedge clk) if (RamBusWE) ramMem[RamBusAddress] <= RamBusDataOut;

    ahb_rambus_bridge #(.ADDR_WIDTH(AW), .STROBE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .RamBusAddress(RamBusAddress), .RamBusnCs(RamBusnCs), .RamBusWE(RamBusWE),
        .RamBusOE(RamBusOE), .RamBusDataOut(RamBusDataOut), .RamBusDataIn(RamBusDataIn),
`ifdef RAMBUS_WAIT_EN
        .RamBusWait(RamBusWait),
`endif
        .RamBusDataOe(RamBusDataOe)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChk++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic bit isLegal(input xfer_t x);
        return (x.size == 3'd2 && x.addr[1:0] == 2'b00) || (x.size == 3'd1 && !x.addr[0]);
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                                input logic [31:0] wd, input int el, input logic er, input logic [31:0] rd);
        vec_t v;
        v.x.addr = a; v.x.size = sz; v.x.wr = wr; v.x.wdata = wd;
        v.expLow = el; v.expResp = er; v.expRd = rd;
        return v;
    endfunction

    // Memory-level reference: what each transfer does to the halfword array and to HRDATA.
    task automatic model(input xfer_t x, output int expLow, output logic expResp);
        logic [AW:0]   a;
        logic [AW-1:0] lo, hi, hw;
        a  = x.addr[AW:0];
        lo = {a[AW:2], 1'b0};
        hi = {a[AW:2], 1'b1};
        hw = a[AW:1];
        expResp = 1'b0;
        if (!isLegal(x)) begin
            expLow = 1; expResp = 1'b1;
        end else if (x.size == 3'd2) begin
            expLow = 2 * P - 1;
            if (x.wr) begin refMem[lo] = x.wdata[15:0]; refMem[hi] = x.wdata[31:16]; end
            else lastRd = {refMem[hi], refMem[lo]};
        end else begin
            expLow = P - 1;
            if (x.wr) refMem[hw] = a[1] ? x.wdata[31:16] : x.wdata[15:0];
            else lastRd = {refMem[hw], refMem[hw]};
        end
    endtask

    task automatic drive(input xfer_t x);
        HSEL = 1'b1; HTRANS = {1'b1, 1'($urandom_range(0, 1))};
        HADDR = x.addr; HSIZE = x.size; HWRITE = x.wr;
    endtask

    // Entry: address phase of x is on the bus, #3 after an edge. Exit: #3 into its final cycle.
    task automatic xfer(input xfer_t x, input int expLow, input logic expResp,
                        input logic [31:0] expRd, input bit nv, input xfer_t nx);
        bit            lg, stb, traceOk, respOk, done;
        int            halves, low, i, half, pos;
        logic [AW:0]   a;
        logic [AW-1:0] ea;
        logic [15:0]   ed;
        lg = isLegal(x); halves = (x.size == 3'd2) ? 2 : 1; a = x.addr[AW:0];
        low = 0; i = 0; traceOk = 1; respOk = 1; done = 0;
        @(posedge clk); #2;
        HWDATA = x.wdata; HSEL = 1'b0; HTRANS = 2'b00;
        #1;
        while (!done && i < 40) begin
            if (lg) begin
                half = i / P; pos = i % P;
                stb  = (pos >= 1 && pos <= S);
                ea   = (halves == 2) ? {a[AW:2], half[0]} : a[AW:1];
                ed   = ((halves == 2) ? half[0] : a[1]) ? x.wdata[31:16] : x.wdata[15:0];
                if (i >= halves * P || RamBusnCs !== 1'b0 || RamBusWE !== (x.wr && stb) ||
                    RamBusOE !== (!x.wr && stb) || RamBusDataOe !== x.wr ||
                    RamBusAddress !== ea || (x.wr && RamBusDataOut !== ed)) traceOk = 0;
            end else if (RamBusnCs !== 1'b1 || RamBusWE !== 1'b0 || RamBusOE !== 1'b0 ||
                         RamBusDataOe !== 1'b0) traceOk = 0;
            if (HRESP !== expResp) respOk = 0;
            if (HREADYOUT === 1'b1) begin
                done = 1;
                if (nv) drive(nx);
            end else begin
                low++; i++;
                @(posedge clk); #3;
            end
        end
        chk("wait_cycles", 64'(low), 64'(expLow));
        chk("hresp", 64'(respOk), 64'd1);
        chk("rambus_trace", 64'(traceOk), 64'd1);
        chk("hrdata", 64'(HRDATA), 64'(expRd));
    endtask

    initial begin
        vec_t  vt [11];
        xfer_t rx [NR];
        bit    pipe [NR];
        xfer_t pa, pb, wx;
        int    el, cnt, r;
        logic  er;
        logic [31:0] ad;

        for (int i = 0; i < (1 << AW); i++) begin
            ramMem[i] = 16'($urandom);
            refMem[i] = ramMem[i];
        end
        ramMem[5] = 16'h1234; refMem[5] = 16'h1234;

        vt[0]  = mk(32'h0000_000A, 3'd1, 1'b0, 32'h0,         3, 1'b0, 32'h1234_1234);
        vt[1]  = mk(32'h0000_0008, 3'd2, 1'b1, 32'hDEAD_BEEF, 7, 1'b0, 32'h1234_1234);
        vt[2]  = mk(32'h0000_0010, 3'd0, 1'b1, 32'h5555_5555, 1, 1'b1, 32'h1234_1234);
        vt[3]  = mk(32'h0000_0002, 3'd2, 1'b0, 32'h0,         1, 1'b1, 32'h1234_1234);
        vt[4]  = mk(32'h0000_0001, 3'd1, 1'b1, 32'h0000_7777, 1, 1'b1, 32'h1234_1234);
        vt[5]  = mk(32'h0000_0000, 3'd3, 1'b0, 32'h0,         1, 1'b1, 32'h1234_1234);
        vt[6]  = mk(32'h0000_0008, 3'd2, 1'b0, 32'h0,         7, 1'b0, 32'hDEAD_BEEF);
        vt[7]  = mk(32'h0000_07FE, 3'd1, 1'b1, 32'hCAFE_0000, 3, 1'b0, 32'hDEAD_BEEF);
        vt[8]  = mk(32'h0000_07FE, 3'd1, 1'b0, 32'h0,         3, 1'b0, 32'hCAFE_CAFE);
        vt[9]  = mk(32'hFFFF_0800, 3'd1, 1'b1, 32'h1234_5A5A, 3, 1'b0, 32'hCAFE_CAFE);
        vt[10] = mk(32'h0000_0000, 3'd1, 1'b0, 32'h0,         3, 1'b0, 32'h5A5A_5A5A);

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #3;
        chk("reset_values", {HREADYOUT, HRESP, HRDATA, RamBusnCs, RamBusWE, RamBusOE,
                             RamBusDataOe, RamBusAddress, RamBusDataOut},
            {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0});

        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = 3'd1;
        @(posedge clk); #3;
        chk("busy_zero_wait", {HREADYOUT, HRESP, RamBusnCs}, 3'b101);
        HSEL = 1'b0; HTRANS = 2'b10;
        @(posedge clk); #3;
        chk("unselected_zero_wait", {HREADYOUT, HRESP, RamBusnCs}, 3'b101);
        HTRANS = 2'b00;

        for (int k = 0; k < 11; k++) begin
            model(vt[k].x, el, er);
            drive(vt[k].x);
            xfer(vt[k].x, vt[k].expLow, vt[k].expResp, vt[k].expRd, 1'b0, vt[k].x);
            @(posedge clk); #3;
        end

        pa = '{addr: 32'h0, size: 3'd1, wr: 1'b1, wdata: 32'h0000_BEAD};
        pb = '{addr: 32'h2, size: 3'd1, wr: 1'b0, wdata: 32'h0};
        model(pa, el, er);
        drive(pa);
        xfer(pa, el, er, lastRd, 1'b1, pb);
        model(pb, el, er);
        xfer(pb, el, er, lastRd, 1'b0, pb);
        @(posedge clk); #3;

        for (int k = 0; k < NR; k++) begin
            r  = $urandom_range(0, 9);
            ad = ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 2047));
            rx[k].wr    = 1'($urandom_range(0, 1));
            rx[k].wdata = $urandom;
            if (r < 4)      begin rx[k].size = 3'd1; rx[k].addr = ad & ~32'h1; end
            else if (r < 8) begin rx[k].size = 3'd2; rx[k].addr = ad & ~32'h3; end
            else            begin rx[k].size = 3'($urandom_range(0, 3)); rx[k].addr = ad; end
            pipe[k] = 1'($urandom_range(0, 1));
        end
        drive(rx[0]);
        for (int k = 0; k < NR; k++) begin
            bit nv;
            nv = (k + 1 < NR) && pipe[k + 1];
            model(rx[k], el, er);
            xfer(rx[k], el, er, lastRd, nv, (k + 1 < NR) ? rx[k + 1] : rx[k]);
            if (!nv && k + 1 < NR) begin
                @(posedge clk); #3;
                drive(rx[k + 1]);
            end
        end
        @(posedge clk); #3;

        cnt = 0;
        for (int i = 0; i < (1 << AW); i++) if (ramMem[i] !== refMem[i]) cnt++;
        chk("memory_contents", 64'(cnt), 64'd0);

        wx = '{addr: 32'h20, size: 3'd2, wr: 1'b1, wdata: 32'h1111_2222};
        drive(wx);
        @(posedge clk); #2;
        HWDATA = wx.wdata; HSEL = 1'b0; HTRANS = 2'b00;
        @(posedge clk); #2;
        rst = 1'b1;
        #1 chk("strobe_before_reset", 64'(RamBusWE), 64'd1);
        @(posedge clk); #3;
        chk("reset_mid_transfer", {RamBusWE, RamBusOE, RamBusnCs, HREADYOUT, HRESP}, 5'b00110);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #3;
            if (RamBusnCs !== 1'b1 || RamBusWE !== 1'b0) cnt++;
        end
        chk("no_second_half", 64'(cnt), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
